// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - RV32M op encodings, FSM states and operand-sign helpers
package muldiv_unit_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // rs1 is treated as signed for these ops
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
           (f == MD_DIV) || (f == MD_REM);
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - sign-magnitude shift-add multiplier / restoring divider datapath
module muldiv_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;
  logic              neg_r;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_val;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] acc_step;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_val;

  // Operand magnitudes and the divide special cases that bypass iteration
  always_comb begin
    a_neg    = op_a_signed(funct3) && a[XLEN-1];
    b_neg    = op_b_signed(funct3) && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = funct3[2] && (b == '0);
    div_ovf  = ((funct3 == MD_DIV) || (funct3 == MD_REM)) && (a == MOST_NEG) && (b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_val = funct3[1] ? a : '1;
    else          special_val = funct3[1] ? '0 : MOST_NEG;
  end

  // One iteration: shift-add for multiply, shift/trial-subtract for divide
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // the remainder can exceed 2^(XLEN-1), so the shifted value needs XLEN+1 bits
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    rem_ge  = rem_sh >= {1'b0, opnd};
    rem_new = rem_ge ? (rem_sh[XLEN-1:0] - opnd) : rem_sh[XLEN-1:0];
    if (op_q[2]) acc_step = {rem_new, acc[XLEN-2:0], rem_ge};
    else         acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  // Sign correction and result selection applied when iteration ends
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                        final_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  final_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               final_val = quot_fix;
      default:                       final_val = rem_fix;
    endcase
  end

  // Operand capture, iteration state and the held result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (load) begin
      op_q  <= funct3;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (funct3[2]) begin
        acc  <= {{XLEN{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{XLEN{1'b0}}, b_mag};
        opnd <= a_mag;
      end
      if (special) result <= special_val;
    end else if (step) begin
      acc <= acc_step;
    end else if (finish) begin
      result <= final_val;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit: FSM, counter and datapath
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN) + 1;

  md_state_e       state;
  md_state_e       state_next;
  logic [CW-1:0]   cnt;
  logic            load;
  logic            step;
  logic            finish;
  logic            special;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and control decode; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (cnt != '0) begin
          step = 1'b1;
        end else begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Iteration counter: loaded with XLEN on acceptance, one decrement per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= CW'(XLEN);
    else if (step) cnt <= cnt - 1'b1;
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .finish  (finish),
    .funct3  (funct3),
    .a       (A),
    .b       (B),
    .special (special),
    .result  (Result)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int n_vec;
  int n_err;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions, in 64-bit integers
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    longint      q;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 0; ua[31:0] = a;
    ub = 0; ub[31:0] = b;
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else begin q = sa / sb; r = q[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'h00000001;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; lat counts cycles from the start cycle to the done cycle
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cnt,
                       output logic post_done, output logic [31:0] post_res);
    @(negedge clk);
    funct3 = f; A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
    lat = -1; busy_cnt = 0; res = '0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        lat = i + 1;
        res = Result;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    @(negedge clk);
    post_done = done;
    post_res  = Result;
  endtask

  vec_t        vecs[$];
  logic [31:0] res;
  logic [31:0] post_res;
  logic        post_done;
  int          lat;
  int          bcnt;
  int          pulses;
  int          d1;
  int          d2;
  logic [31:0] r1;
  logic [31:0] r2;
  logic        busy_after;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; funct3 = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset Result", Result, 32'd0);
    reset = 1'b0;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34});
    vecs.push_back('{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34});
    vecs.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34});
    vecs.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34});
    vecs.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{3'd5, 32'd100,        32'd7,        32'd14,       34});
    vecs.push_back('{3'd7, 32'd100,        32'd7,        32'd2,        34});
    vecs.push_back('{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'd6, 32'd5,          32'd0,        32'd5,        1});
    vecs.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1});
    vecs.push_back('{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        34});
    vecs.push_back('{3'd5, 32'hFFFFFFFF,   32'h80000001, 32'd1,        34});
    vecs.push_back('{3'd7, 32'hFFFFFFFF,   32'h80000001, 32'h7FFFFFFE, 34});
    vecs.push_back('{3'd4, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    vecs.push_back('{3'd6, 32'd7,          32'hFFFFFFFE, 32'd1,        34});
    vecs.push_back('{3'd1, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 34});

    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bcnt, post_done, post_res);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].lat - 1));
      check($sformatf("vec%0d done pulse width", i), 32'(post_done), 32'd0);
      check($sformatf("vec%0d result hold", i), post_res, vecs[i].exp);
    end

    for (int i = 0; i < 80; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = rnd_opnd();
      b = rnd_opnd();
      do_op(f, a, b, res, lat, bcnt, post_done, post_res);
      check($sformatf("rand%0d f=%0d a=%h b=%h result", i, f, a, b), res, ref_md(f, a, b));
      check($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(f, a, b)));
    end

    // start re-asserted with new operands during CALC is ignored
    @(negedge clk);
    funct3 = 3'd0; A = 32'd7; B = 32'hFFFFFFFD; start = 1'b1;
    @(posedge clk);
    pulses = 0; d1 = -1; r1 = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i >= 4 && i <= 8) begin
        start = 1'b1; A = 32'd123; funct3 = 3'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (d1 < 0) begin d1 = i + 1; r1 = Result; end
      end
    end
    start = 1'b0;
    check("reassert done pulses", 32'(pulses), 32'd1);
    check("reassert result", r1, 32'hFFFFFFEB);
    check("reassert latency", 32'(d1), 32'd34);

    // start held high through DONE: next op accepted only once back in IDLE
    @(negedge clk);
    funct3 = 3'd5; A = 32'd100; B = 32'd7; start = 1'b1;
    d1 = -1; d2 = -1; r1 = '0; r2 = '0; busy_after = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (d1 >= 0 && i == d1 + 1) busy_after = busy;
      if (done) begin
        if (d1 < 0) begin
          d1 = i; r1 = Result; funct3 = 3'd7;
        end else begin
          d2 = i; r2 = Result; start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("held start first result", r1, 32'd14);
    check("held start idle gap busy", 32'(busy_after), 32'd0);
    check("held start second result", r2, 32'd2);
    check("held start done spacing", 32'(d2 - d1), 32'd35);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    funct3 = 3'd0; A = 32'd3; B = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset Result", Result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("aborted op done pulses", 32'(pulses), 32'd0);
    do_op(3'd5, 32'd100, 32'd7, res, lat, bcnt, post_done, post_res);
    check("post reset result", res, 32'd14);
    check("post reset latency", 32'(lat), 32'd34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
